// File: rtl/paralelo_serial_tx_pkg.sv
// Shared definitions for the parallel-to-serial transmitter: FSM encoding,
// the idle/comma symbol and the default sync length.
package paralelo_serial_tx_pkg;

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } tx_state_t;

    localparam logic [7:0] IDLE_BYTE_DEF   = 8'hBC;
    localparam int         SYNC_COMMAS_DEF = 4;

    // Width of a counter that must reach n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/paralelo_serial_tx_if.sv
// Byte-side handshake plus line-side outputs of the serial transmitter.
// master: the byte source / line observer; slave: the transmitter.
interface paralelo_serial_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              valid_in;
    logic              ready;
    logic              data_out;
    logic              active;

    modport master (
        output data_in,
        output valid_in,
        input  ready,
        input  data_out,
        input  active
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output ready,
        output data_out,
        output active
    );
endinterface

// File: rtl/paralelo_serial_tx_hold_reg.sv
// One-byte holding register with full flag, used by paralelo_serial_tx when
// built with PS_TX_HOLD_EN. A write has priority over a read on the same
// edge, so a load that drains the slot while a new byte arrives keeps it full.
`ifdef PS_TX_HOLD_EN
module tx_hold_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] q,
    output logic              full
);

    // Full flag: set by a write, cleared by a read without a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
        end else if (wr) begin
            full <= 1'b1;
        end else if (rd) begin
            full <= 1'b0;
        end
    end

    // Held byte; only meaningful while full is set, so no reset needed.
    always_ff @(posedge clk) begin
        if (wr) begin
            q <= din;
        end
    end

endmodule
`endif

// File: rtl/paralelo_serial_tx.sv
// Parallel-to-serial transmitter: sends SYNC_COMMAS idle commas after reset,
// then accepted bytes MSB first, filling empty slots with IDLE_BYTE.
// Optional build macro PS_TX_HOLD_EN adds a one-byte holding register so a
// byte can be accepted anywhere inside a slot.
module paralelo_serial_tx
    import paralelo_serial_tx_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter logic [DATA_W-1:0] IDLE_BYTE   = IDLE_BYTE_DEF,
    parameter int                SYNC_COMMAS = SYNC_COMMAS_DEF
) (
    input  logic                  clk_32f,
    input  logic                  reset_L,
    paralelo_serial_tx_if.slave   tx
);

    localparam int                CNT_W      = cnt_w(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(DATA_W - 1);
    localparam logic [3:0]        LAST_COMMA = 4'(SYNC_COMMAS - 1);

    tx_state_t         state;
    tx_state_t         state_next;
    logic [DATA_W-1:0] shift_reg;
    logic [CNT_W-1:0]  bit_cnt;
    logic [3:0]        comma_cnt;
    logic              load;
    logic              ready_int;
    logic              accept;
    logic [DATA_W-1:0] next_byte;

    assign load   = (bit_cnt == LAST_BIT);
    assign accept = tx.valid_in && ready_int;

`ifdef PS_TX_HOLD_EN
    logic              hold_full;
    logic [DATA_W-1:0] hold_q;
    logic              hold_wr;
    logic              hold_rd;

    // Accepts mid-slot (or alongside a draining load) go to the hold slot;
    // an accept on a load edge with the slot empty bypasses it.
    assign ready_int = (state == ST_RUN) && (!hold_full || load);
    assign hold_wr   = accept && (hold_full || !load);
    assign hold_rd   = load && hold_full;

    tx_hold_reg #(
        .DATA_W (DATA_W)
    ) u_hold (
        .clk   (clk_32f),
        .rst_n (reset_L),
        .wr    (hold_wr),
        .rd    (hold_rd),
        .din   (tx.data_in),
        .q     (hold_q),
        .full  (hold_full)
    );

    // Next byte to load: held byte first to keep order, then bypass, then idle.
    always_comb begin
        next_byte = IDLE_BYTE;
        if (hold_full) begin
            next_byte = hold_q;
        end else if (accept) begin
            next_byte = tx.data_in;
        end
    end
`else
    assign ready_int = (state == ST_RUN) && load;

    // Next byte to load: accepted data, otherwise idle comma.
    always_comb begin
        next_byte = IDLE_BYTE;
        if (accept) begin
            next_byte = tx.data_in;
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state <= ST_SYNC;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: leave SYNC on the load of the last sync comma.
    always_comb begin
        state_next = state;
        if (state == ST_SYNC && load && comma_cnt == LAST_COMMA) begin
            state_next = ST_RUN;
        end
    end

    // Count commas loaded while in SYNC.
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            comma_cnt <= 4'd0;
        end else if (state == ST_SYNC && load) begin
            comma_cnt <= comma_cnt + 4'd1;
        end
    end

    // Byte slot: load on the last bit position, otherwise shift left.
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            shift_reg <= '0;
            bit_cnt   <= LAST_BIT;
        end else if (load) begin
            shift_reg <= next_byte;
            bit_cnt   <= '0;
        end else begin
            shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
            bit_cnt   <= bit_cnt + CNT_W'(1);
        end
    end

    assign tx.ready    = ready_int;
    assign tx.data_out = shift_reg[DATA_W-1];
    assign tx.active   = (state == ST_RUN);

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Directed bench for paralelo_serial_tx: slot-level vector table plus a
// hand-written mid-byte reset sequence. Works for both builds.
module tb_paralelo_serial_tx;

`ifdef PS_TX_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    typedef struct {
        logic       v;          // valid_in at the load edge
        logic [7:0] d;          // data_in at the load edge
        int         mid;        // sample index after which a mid-slot pulse is offered, -1 none
        logic [7:0] dmid;       // data offered mid-slot
        logic       exp_rdy;    // ready just before the load edge
        logic       exp_mrdy;   // ready during the mid-slot pulse
        logic [7:0] exp_byte;   // byte seen on data_out during this slot
        logic       exp_act;    // active at the end of the slot
        string      name;
    } vec_t;

    logic clk = 1'b0;
    logic reset_L = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    vec_t tbl[$];
    vec_t tbl2[$];

    paralelo_serial_tx_if #(.DATA_W(8)) bus ();

    paralelo_serial_tx dut (
        .clk_32f (clk),
        .reset_L (reset_L),
        .tx      (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic v, input logic [7:0] d, input int mid,
                                input logic [7:0] dmid, input logic exp_rdy,
                                input logic exp_mrdy, input logic [7:0] exp_byte,
                                input logic exp_act, input string name);
        vec_t r;
        r.v = v; r.d = d; r.mid = mid; r.dmid = dmid; r.exp_rdy = exp_rdy;
        r.exp_mrdy = exp_mrdy; r.exp_byte = exp_byte; r.exp_act = exp_act; r.name = name;
        return r;
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h, expected %02h", name, got, exp);
        end
    endtask

    // Drive one full byte slot, starting #1 after the edge before the load edge.
    task automatic apply_vec(input vec_t t);
        logic [7:0] got;
        got = '0;
        bus.valid_in = t.v;
        bus.data_in  = t.d;
        #1;
        check({t.name, "_ready"}, {7'd0, bus.ready}, {7'd0, t.exp_rdy});
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            got[7-i]     = bus.data_out;
            bus.valid_in = 1'b0;
            if (i == t.mid) begin
                bus.valid_in = 1'b1;
                bus.data_in  = t.dmid;
                #1;
                check({t.name, "_midready"}, {7'd0, bus.ready}, {7'd0, t.exp_mrdy});
            end
        end
        check({t.name, "_byte"}, got, t.exp_byte);
        check({t.name, "_active"}, {7'd0, bus.active}, {7'd0, t.exp_act});
    endtask

    initial begin
        logic [7:0] part;

        // Reset, sync commas, streaming, idle fill, unescaped 0xBC.
        tbl.push_back(mk(0, 8'h00, -1, 8'h00, 0, 0, 8'hBC, 0, "sync0"));
        tbl.push_back(mk(0, 8'h00, -1, 8'h00, 0, 0, 8'hBC, 0, "sync1"));
        tbl.push_back(mk(1, 8'h77, -1, 8'h00, 0, 0, 8'hBC, 0, "sync2_ignored"));
        tbl.push_back(mk(0, 8'h00, -1, 8'h00, 0, 0, 8'hBC, 1, "sync3"));
        tbl.push_back(mk(1, 8'hA5, -1, 8'h00, 1, 0, 8'hA5, 1, "data_a5"));
        tbl.push_back(mk(1, 8'h3C, -1, 8'h00, 1, 0, 8'h3C, 1, "data_3c"));
        tbl.push_back(mk(1, 8'hFF, -1, 8'h00, 1, 0, 8'hFF, 1, "data_ff"));
        tbl.push_back(mk(0, 8'h00, -1, 8'h00, 1, 0, 8'hBC, 1, "idle_fill"));
        tbl.push_back(mk(1, 8'hBC, -1, 8'h00, 1, 0, 8'hBC, 1, "data_bc"));
        tbl.push_back(mk(1, 8'h00, -1, 8'h00, 1, 0, 8'h00, 1, "data_00"));
        tbl.push_back(mk(1, 8'h01, -1, 8'h00, 1, 0, 8'h01, 1, "data_01"));
        // Mid-slot offer: refused in the base build, held and sent next with the hold register.
        tbl.push_back(mk(0, 8'h00, 3, 8'h5A, 1, HOLD, 8'hBC, 1, "mid_5a"));
        tbl.push_back(mk(0, 8'h00, -1, 8'h00, 1, 0, HOLD ? 8'h5A : 8'hBC, 1, "after_mid"));
        tbl.push_back(mk(0, 8'h00, -1, 8'h00, 1, 0, 8'hBC, 1, "idle2"));
        if (HOLD) begin
            tbl.push_back(mk(0, 8'h00, 2, 8'h11, 1, 1, 8'hBC, 1, "hold_11"));
            tbl.push_back(mk(1, 8'h22, -1, 8'h00, 1, 0, 8'h11, 1, "send_11_refill_22"));
            tbl.push_back(mk(0, 8'h00, -1, 8'h00, 1, 0, 8'h22, 1, "send_22"));
            tbl.push_back(mk(0, 8'h00, -1, 8'h00, 1, 0, 8'hBC, 1, "idle3"));
        end
        // After a mid-byte reset: 0x81 refused through all four commas.
        tbl2.push_back(mk(1, 8'h81, -1, 8'h00, 0, 0, 8'hBC, 0, "rsync0"));
        tbl2.push_back(mk(1, 8'h81, -1, 8'h00, 0, 0, 8'hBC, 0, "rsync1"));
        tbl2.push_back(mk(1, 8'h81, -1, 8'h00, 0, 0, 8'hBC, 0, "rsync2"));
        tbl2.push_back(mk(1, 8'h81, -1, 8'h00, 0, 0, 8'hBC, 1, "rsync3"));
        tbl2.push_back(mk(1, 8'h81, -1, 8'h00, 1, 0, 8'h81, 1, "r_data_81"));
        tbl2.push_back(mk(0, 8'h00, -1, 8'h00, 1, 0, 8'hBC, 1, "r_idle"));

        bus.valid_in = 1'b0;
        bus.data_in  = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check("rst_data_out", {7'd0, bus.data_out}, 8'd0);
        check("rst_ready",    {7'd0, bus.ready},    8'd0);
        check("rst_active",   {7'd0, bus.active},   8'd0);
        reset_L = 1'b1;

        foreach (tbl[k]) apply_vec(tbl[k]);

        // Reset asserted while data byte 0x81 is showing bit 3.
        part = '0;
        bus.valid_in = 1'b1;
        bus.data_in  = 8'h81;
        #1;
        check("r81_ready", {7'd0, bus.ready}, 8'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            part[7-i]    = bus.data_out;
            bus.valid_in = 1'b0;
        end
        check("r81_partial", part, 8'h80);
        reset_L = 1'b0;
        #1;
        check("midrst_data_out", {7'd0, bus.data_out}, 8'd0);
        check("midrst_active",   {7'd0, bus.active},   8'd0);
        check("midrst_ready",    {7'd0, bus.ready},    8'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_L = 1'b1;

        foreach (tbl2[k]) apply_vec(tbl2[k]);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
